// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// Register window (io_addr[3:2]): 0 TXDATA, 1 STATUS, 2 DIV, 3 reserved.
// Reads are combinational; writes commit on the rising clock edge with io_op=1.
module uart_tx_mmio #(
  parameter int DEFAULT_DIV = 868,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_addr,
  input  logic        io_op,
  input  logic [3:0]  io_mask,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  logic [1:0]    state_r;
  logic [15:0]   div_r;
  logic [15:0]   cyc_cnt_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          overflow_r;
  logic [7:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;

  logic [1:0]    sel_s;
  logic          push_s;
  logic          push_ok_s;
  logic          pop_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          bit_end_s;
  logic [15:0]   eff_div_s;
  logic [15:0]   reload_s;
  logic [7:0]    head_s;
  logic          ovf_clear_s;
  logic          unused_s;

  assign sel_s        = io_addr[3:2];
  assign fifo_full_s  = (count_r == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty_s = (count_r == {(AW+1){1'b0}});
  assign bit_end_s    = (cyc_cnt_r == 16'd0);
  // A divisor of zero would never end a bit; run it as one cycle per bit.
  assign eff_div_s    = (div_r == 16'd0) ? 16'd1 : div_r;
  assign reload_s     = eff_div_s - 16'd1;
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign push_s       = io_op && (sel_s == REG_TXDATA) && io_mask[0];
  // The FSM pops when idle, or at the last cycle of a stop bit for back-to-back frames.
  assign pop_s        = !fifo_empty_s &&
                        ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign push_ok_s    = push_s && (!fifo_full_s || pop_s);
  assign ovf_clear_s  = io_op && (sel_s == REG_STATUS) && io_mask[0] && io_wdata[3];
  assign unused_s     = ^{io_addr[31:4], io_addr[1:0], io_mask[3:2], io_wdata[31:16]};
  assign io_tx        = tx_r;

  // Register read mux; all fields come from reset-cleared registers.
  always_comb begin
    io_rdata = 32'd0;
    case (sel_s)
      REG_TXDATA: io_rdata = {fifo_full_s, 31'd0};
      REG_STATUS: io_rdata = {24'd0, 4'(count_r), overflow_r, fifo_empty_s,
                              fifo_full_s, (state_r != ST_IDLE)};
      REG_DIV:    io_rdata = {16'd0, div_r};
      default:    io_rdata = 32'd0;
    endcase
  end

  // FIFO storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'd0;
      end
    end else begin
      if (push_ok_s) begin
        fifo_mem_r[wr_ptr_r] <= io_wdata[7:0];
        wr_ptr_r <= (wr_ptr_r == AW'(FIFO_DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == AW'(FIFO_DEPTH - 1)) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag: set on a dropped push, cleared by software via STATUS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clear_s) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Baud divisor register with per-byte-lane write enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= 16'(DEFAULT_DIV);
    end else if (io_op && (sel_s == REG_DIV)) begin
      if (io_mask[0]) div_r[7:0]  <= io_wdata[7:0];
      if (io_mask[1]) div_r[15:8] <= io_wdata[15:8];
    end else begin
      div_r <= div_r;
    end
  end

  // Transmit FSM; the cycle counter is reloaded from the divisor at each bit start,
  // so a divisor change only affects the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      tx_r      <= 1'b1;
      cyc_cnt_r <= 16'd0;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          tx_r <= 1'b1;
          if (pop_s) begin
            shift_r   <= head_s;
            cyc_cnt_r <= reload_s;
            tx_r      <= 1'b0;
            state_r   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r   <= ST_DATA;
            tx_r      <= shift_r[0];
            bit_cnt_r <= 3'd0;
            cyc_cnt_r <= reload_s;
          end else begin
            cyc_cnt_r <= cyc_cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            cyc_cnt_r <= reload_s;
            if (bit_cnt_r == 3'd7) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            if (pop_s) begin
              shift_r   <= head_s;
              cyc_cnt_r <= reload_s;
              tx_r      <= 1'b0;
              state_r   <= ST_START;
            end else begin
              tx_r    <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            cyc_cnt_r <= cyc_cnt_r - 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio: register access, framing, FIFO and reset.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io_addr;
  logic        io_op;
  logic [3:0]  io_mask;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_tx;

  int n_vec  = 0;
  int n_fail = 0;

  logic [9:0] frame;

  uart_tx_mmio #(.DEFAULT_DIV(868), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_op    (io_op),
    .io_mask  (io_mask),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_tx    (io_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_tx(input string tag, input logic exp);
    check(tag, {31'd0, io_tx}, {31'd0, exp});
  endtask

  // combinational read, done shortly after a falling edge
  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    io_op   = 1'b0;
    io_addr = a;
    #1;
    check(tag, io_rdata, exp);
  endtask

  // single write committed at the next rising edge; returns at the following falling edge
  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    io_op    = 1'b1;
    io_addr  = a;
    io_mask  = m;
    io_wdata = d;
    @(negedge clk);
    io_op   = 1'b0;
    io_mask = 4'd0;
  endtask

  // n TXDATA pushes on consecutive edges: first, first+1, ...
  task automatic push_run(input int n, input logic [7:0] first);
    io_op   = 1'b1;
    io_addr = 32'h0;
    io_mask = 4'b0001;
    for (int k = 0; k < n; k++) begin
      io_wdata = {24'd0, first + 8'(k)};
      @(negedge clk);
    end
    io_op   = 1'b0;
    io_mask = 4'd0;
  endtask

  initial begin
    rst = 1'b1; io_op = 1'b0; io_addr = 32'h0; io_mask = 4'd0; io_wdata = 32'd0;

    // reset values, during and after reset
    @(negedge clk);
    check_tx("tx_in_reset", 1'b1);
    rd(32'h4, "status_in_reset", 32'h0000_0004);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(32'h4, "status_reset", 32'h0000_0004);
    rd(32'h8, "div_reset", 32'd868);
    rd(32'h0, "txdata_reset", 32'h0);
    check_tx("tx_reset", 1'b1);

    // partial DIV write, reserved offset, masked-off TXDATA write
    wr(32'h8, 4'b0010, 32'h0000_ABCD);
    rd(32'h8, "div_lane1", 32'h0000_AB64);
    wr(32'hC, 4'b1111, 32'hFFFF_FFFF);
    rd(32'hC, "reserved", 32'h0);
    wr(32'h0, 4'b0000, 32'h0000_0055);
    repeat (3) @(negedge clk);
    rd(32'h4, "txdata_nomask_status", 32'h0000_0004);
    check_tx("txdata_nomask_tx", 1'b1);

    // single byte 0xA5 at DIV=4
    wr(32'h8, 4'b0011, 32'd4);
    rd(32'h8, "div4", 32'd4);
    wr(32'h0, 4'b0001, 32'h0000_00A5);
    rd(32'h4, "a5_queued", 32'h0000_0010);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check_tx($sformatf("a5_tx_c%0d", i), frame[i/4]);
      if (i == 0 || i == 39) rd(32'h4, $sformatf("a5_busy_c%0d", i), 32'h0000_0005);
    end
    @(negedge clk);
    rd(32'h4, "a5_done", 32'h0000_0004);
    check_tx("a5_idle_tx", 1'b1);

    // DIV=0 behaves as 1 cycle per bit
    wr(32'h8, 4'b0011, 32'd0);
    rd(32'h8, "div0_read", 32'd0);
    wr(32'h0, 4'b0001, 32'h0000_005A);
    frame = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_tx($sformatf("div0_tx_c%0d", i), frame[i]);
    end
    @(negedge clk);
    rd(32'h4, "div0_done", 32'h0000_0004);

    // back-to-back 0x01,0x02,0x03 at DIV=2: 60 cycles, no gap
    wr(32'h8, 4'b0011, 32'd2);
    push_run(3, 8'h01);
    rd(32'h4, "b2b_after_push", 32'h0000_0021);
    for (int i = 1; i < 60; i++) begin
      frame = {1'b1, 8'((i / 20) + 1), 1'b0};
      check_tx($sformatf("b2b_tx_c%0d", i), frame[(i % 20) / 2]);
      if (i == 19) rd(32'h4, "b2b_cnt2", 32'h0000_0021);
      if (i == 20) rd(32'h4, "b2b_cnt1", 32'h0000_0011);
      if (i == 39) rd(32'h4, "b2b_cnt1_end", 32'h0000_0011);
      if (i == 40) rd(32'h4, "b2b_cnt0", 32'h0000_0005);
      @(negedge clk);
    end
    rd(32'h4, "b2b_done", 32'h0000_0004);

    // overflow at DIV=100: six pushes, one popped, four queued, one dropped
    wr(32'h8, 4'b0011, 32'd100);
    push_run(6, 8'h20);
    rd(32'h4, "ovf_status", 32'h0000_004B);
    rd(32'h0, "ovf_txdata_full", 32'h8000_0000);
    wr(32'h4, 4'b0001, 32'h0000_0000);
    rd(32'h4, "ovf_keep", 32'h0000_004B);
    wr(32'h4, 4'b0001, 32'h0000_0008);
    rd(32'h4, "ovf_cleared", 32'h0000_0043);
    rst = 1'b1;
    #1;
    rd(32'h4, "ovf_rst_status", 32'h0000_0004);
    @(negedge clk);
    rst = 1'b0;

    // full FIFO with push exactly on the stop-end pop edge
    wr(32'h8, 4'b0011, 32'd2);
    push_run(5, 8'h30);
    rd(32'h4, "full_status", 32'h0000_0043);
    repeat (16) @(negedge clk);
    wr(32'h0, 4'b0001, 32'h0000_0077);
    rd(32'h4, "full_pop_push", 32'h0000_0043);
    wr(32'h0, 4'b0001, 32'h0000_0078);
    rd(32'h4, "full_no_pop_push", 32'h0000_004B);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // mid-frame reset during data bit 3 of 0x00, second byte queued
    wr(32'h8, 4'b0011, 32'd4);
    push_run(2, 8'h00);
    repeat (17) @(negedge clk);
    check_tx("mid_bit3_low", 1'b0);
    #1 rst = 1'b1;
    #1;
    check_tx("mid_rst_tx_async", 1'b1);
    rd(32'h4, "mid_rst_status", 32'h0000_0004);
    rd(32'h8, "mid_rst_div", 32'd868);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_tx($sformatf("mid_after_c%0d", i), 1'b1);
    end
    rd(32'h4, "mid_after_status", 32'h0000_0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
